// File: rtl/msx_mouse_pkg.sv
// rtl/msx_mouse_pkg.sv - shared types and constants for the MSX mouse reader
package msx_mouse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TOGGLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int NIBBLES_PER_FRAME = 4;
   localparam int DEVICE_TIMEOUT    = 100000;

   function automatic logic [7:0] negate8(input logic [7:0] v);
      return 8'(~v + 8'd1);
   endfunction

endpackage

// File: rtl/msx_mouse_reader_sync2.sv
// rtl/msx_mouse_reader_sync2.sv - two-flop synchronizer, clears to all ones
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Port pins idle high, so clearing to ones looks like "nothing pressed".
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/msx_mouse_reader.sv
// rtl/msx_mouse_reader.sv - polls an MSX mouse via STR toggles, outputs dx/dy/buttons
module msx_mouse_reader
   import msx_mouse_pkg::*;
#(
   parameter int POLL_PERIOD    = 358000,
   parameter int SETTLE_CYCLES  = 64,
   parameter int MISS_LIMIT     = 3,
   parameter bit NEGATE_X       = 1'b0,
   parameter int RESYNC_TIMEOUT = DEVICE_TIMEOUT
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [5:0] joy_in,
   output logic       str_out,
   output logic [7:0] dx,
   output logic [7:0] dy,
   output logic [1:0] buttons,
   output logic       valid,
   output logic       mouse_present,
   output logic       busy
);

   localparam int PW = $clog2(POLL_PERIOD);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_PERIOD - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [MW-1:0] MISS_MAX    = MW'(MISS_LIMIT);
   localparam logic [1:0]    IDX_LAST    = 2'(NIBBLES_PER_FRAME - 1);

   if (POLL_PERIOD <= RESYNC_TIMEOUT) begin : g_poll_period_check
      $error("POLL_PERIOD must exceed the device resync timeout");
   end

   state_t                              state_q, state_d;
   logic [PW-1:0]                       poll_cnt;
   logic [SW-1:0]                       settle_cnt;
   logic [1:0]                          idx;
   logic [NIBBLES_PER_FRAME-1:0][3:0]   nib;
   logic [1:0]                          btn;
   logic [MW-1:0]                       miss_cnt, miss_inc;
   logic [5:0]                          joy_sync;
   logic                                miss;
   logic [7:0]                          dx_raw, dx_next;

   sync2 #(.WIDTH(6)) u_sync (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (joy_in),
      .q       (joy_sync)
   );

   assign busy = (state_q != IDLE);

   always_comb begin
      miss     = (nib == '1);
      miss_inc = (miss_cnt == MISS_MAX) ? MISS_MAX : miss_cnt + 1'b1;
      dx_raw   = {nib[0], nib[1]};
      dx_next  = NEGATE_X ? negate8(dx_raw) : dx_raw;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable && poll_cnt == POLL_LAST) state_d = TOGGLE;
         TOGGLE:  state_d = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
         SAMPLE:  state_d = (idx == IDX_LAST) ? DONE : TOGGLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Dropping enable abandons the frame; the device resyncs during the next full poll wait.
      if (!enable) state_d = IDLE;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt      <= '0;
         settle_cnt    <= '0;
         idx           <= '0;
         nib           <= '0;
         btn           <= '0;
         miss_cnt      <= '0;
         str_out       <= 1'b0;
         dx            <= '0;
         dy            <= '0;
         buttons       <= '0;
         valid         <= 1'b0;
         mouse_present <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!enable || poll_cnt == POLL_LAST) poll_cnt <= '0;
               else                                  poll_cnt <= poll_cnt + 1'b1;
               if (enable && poll_cnt == POLL_LAST) idx <= '0;
            end
            TOGGLE: if (enable) begin
               str_out    <= ~str_out;
               settle_cnt <= '0;
            end
            SETTLE: if (enable) settle_cnt <= settle_cnt + 1'b1;
            SAMPLE: if (enable) begin
               nib[idx] <= joy_sync[3:0];
               if (idx == IDX_LAST) btn <= ~joy_sync[5:4];
               else                 idx <= idx + 1'b1;
            end
            DONE: if (enable) begin
               dx      <= miss ? 8'hFF : dx_next;
               dy      <= {nib[2], nib[3]};
               buttons <= btn;
               valid   <= 1'b1;
               if (miss) begin
                  miss_cnt <= miss_inc;
                  if (miss_inc == MISS_MAX) mouse_present <= 1'b0;
               end else begin
                  miss_cnt      <= '0;
                  mouse_present <= 1'b1;
               end
            end
            default: ;
         endcase
         if (!enable) poll_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// tb/tb_msx_mouse_reader.sv - self-checking bench for msx_mouse_reader with a mouse device model
module tb_msx_mouse_reader;

   localparam int PP          = 1000;
   localparam int SC          = 8;
   localparam int ML          = 3;
   localparam int DEV_TO      = 500;
   localparam int FRAME_BOUND = PP + 4 * (SC + 2) + 50;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable  = 1'b0;
   logic [5:0] joy_in  = 6'h3F;

   logic       str_out, str_out_n;
   logic [7:0] dx, dy, dx_n, dy_n;
   logic [1:0] buttons, buttons_n;
   logic       valid, valid_n, mouse_present, present_n, busy, busy_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   msx_mouse_reader #(.POLL_PERIOD(PP), .SETTLE_CYCLES(SC), .MISS_LIMIT(ML),
                      .NEGATE_X(1'b0), .RESYNC_TIMEOUT(DEV_TO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .joy_in(joy_in),
      .str_out(str_out), .dx(dx), .dy(dy), .buttons(buttons), .valid(valid),
      .mouse_present(mouse_present), .busy(busy));

   msx_mouse_reader #(.POLL_PERIOD(PP), .SETTLE_CYCLES(SC), .MISS_LIMIT(ML),
                      .NEGATE_X(1'b1), .RESYNC_TIMEOUT(DEV_TO)) dut_n (
      .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .joy_in(joy_in),
      .str_out(str_out_n), .dx(dx_n), .dy(dy_n), .buttons(buttons_n), .valid(valid_n),
      .mouse_present(present_n), .busy(busy_n));

   // Device model: nibble k on the k-th STR edge, forgets position after DEV_TO quiet cycles.
   logic [3:0] m_nib [4];
   logic [1:0] m_btn   = 2'b00;
   bit         m_float = 1'b1;
   int         m_k     = 0;
   int         m_idle  = 0;
   logic       m_str_prev = 1'b0;

   always @(negedge clk_sys) begin
      if (str_out !== m_str_prev) begin
         m_str_prev = str_out;
         m_idle     = 0;
         if (m_float || m_k > 3) joy_in = 6'h3F;
         else                    joy_in = {~m_btn, m_nib[m_k]};
         m_k = m_k + 1;
      end else if (m_idle < DEV_TO) begin
         m_idle = m_idle + 1;
         if (m_idle == DEV_TO) begin
            m_k    = 0;
            joy_in = 6'h3F;
         end
      end
   end

   int ref_miss    = 0;
   bit ref_present = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic predict(input logic [15:0] word, input logic [1:0] btn, input bit flt,
                          output logic [7:0] edx, output logic [7:0] edx_n, output logic [7:0] edy,
                          output logic [1:0] ebtn, output bit epres);
      bit is_miss;
      logic [15:0] w;
      w       = flt ? 16'hFFFF : word;
      is_miss = (w == 16'hFFFF);
      edx     = w[15:8];
      edx_n   = is_miss ? 8'hFF : 8'((256 - int'(w[15:8])) % 256);
      edy     = w[7:0];
      ebtn    = flt ? 2'b00 : btn;
      if (is_miss) begin
         ref_miss = (ref_miss < ML) ? ref_miss + 1 : ML;
         if (ref_miss == ML) ref_present = 1'b0;
      end else begin
         ref_miss    = 0;
         ref_present = 1'b1;
      end
      epres = ref_present;
   endtask

   task automatic load_device(input logic [15:0] word, input logic [1:0] btn, input bit flt);
      m_nib[0] = word[15:12];
      m_nib[1] = word[11:8];
      m_nib[2] = word[7:4];
      m_nib[3] = word[3:0];
      m_btn    = btn;
      m_float  = flt;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] edx, input logic [7:0] edx_n,
                            input logic [7:0] edy, input logic [1:0] ebtn, input bit epres);
      int   cyc, edges, last_edge, lat;
      bit   got, spacing_ok;
      logic prev;
      cyc = 0; edges = 0; last_edge = 0; lat = -1; got = 0; spacing_ok = 1;
      prev = str_out;
      while (!got && cyc < FRAME_BOUND) begin
         @(negedge clk_sys);
         cyc++;
         if (str_out !== prev) begin
            prev = str_out;
            if (edges > 0 && cyc - last_edge != SC + 2) spacing_ok = 0;
            edges++;
            last_edge = cyc;
         end
         if (valid) begin
            got = 1;
            lat = cyc - last_edge;
         end
      end
      check({tag, ".valid_seen"}, 32'(got), 1);
      if (got) begin
         check({tag, ".str_edges"}, 32'(edges), 4);
         check({tag, ".toggle_spacing"}, 32'(spacing_ok), 1);
         check({tag, ".sample_latency"}, 32'(lat), SC + 2);
         check({tag, ".dx"}, 32'(dx), 32'(edx));
         check({tag, ".dy"}, 32'(dy), 32'(edy));
         check({tag, ".buttons"}, 32'(buttons), 32'(ebtn));
         check({tag, ".present"}, 32'(mouse_present), 32'(epres));
         check({tag, ".neg_valid"}, 32'(valid_n), 1);
         check({tag, ".neg_dx"}, 32'(dx_n), 32'(edx_n));
         @(negedge clk_sys);
         check({tag, ".valid_one_cycle"}, 32'(valid), 0);
      end
   endtask

   typedef struct {
      logic [15:0] word;
      logic [1:0]  btn;
      bit          flt;
      logic [7:0]  exp_dx;
      logic [7:0]  exp_dx_n;
      logic [7:0]  exp_dy;
      logic [1:0]  exp_btn;
      bit          exp_present;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [7:0] pdx, pdxn, pdy;
      logic [1:0] pbtn;
      bit         ppres;
      int         cyc, edges, vcount, scount;
      logic       prev, str_hold;

      vecs[0] = '{16'h05FD, 2'b00, 1'b0, 8'h05, 8'hFB, 8'hFD, 2'b00, 1'b1};
      vecs[1] = '{16'h1234, 2'b01, 1'b0, 8'h12, 8'hEE, 8'h34, 2'b01, 1'b1};
      vecs[2] = '{16'h0000, 2'b00, 1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b1};
      vecs[3] = '{16'h0000, 2'b00, 1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b1};
      vecs[4] = '{16'h0000, 2'b00, 1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b0};
      vecs[5] = '{16'h0000, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1};
      vecs[6] = '{16'h8080, 2'b11, 1'b0, 8'h80, 8'h80, 8'h80, 2'b11, 1'b1};
      vecs[7] = '{16'hFFFF, 2'b11, 1'b0, 8'hFF, 8'hFF, 8'hFF, 2'b11, 1'b1};

      repeat (5) @(negedge clk_sys);
      check("reset.str_out", 32'(str_out), 0);
      check("reset.valid", 32'(valid), 0);
      check("reset.present", 32'(mouse_present), 0);
      check("reset.busy", 32'(busy), 0);
      reset_n = 1'b1;
      enable  = 1'b1;

      for (int i = 0; i < 8; i++) begin
         load_device(vecs[i].word, vecs[i].btn, vecs[i].flt);
         predict(vecs[i].word, vecs[i].btn, vecs[i].flt, pdx, pdxn, pdy, pbtn, ppres);
         run_frame($sformatf("vec%0d", i), vecs[i].exp_dx, vecs[i].exp_dx_n,
                   vecs[i].exp_dy, vecs[i].exp_btn, vecs[i].exp_present);
      end

      // Asynchronous reset asserted in the middle of a settle window.
      cyc = 0; prev = str_out;
      while (str_out === prev && cyc < FRAME_BOUND) begin
         @(negedge clk_sys);
         cyc++;
      end
      check("midreset.edge_seen", 32'(cyc < FRAME_BOUND), 1);
      repeat (3) @(negedge clk_sys);
      check("midreset.busy_before", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check("midreset.str_out", 32'(str_out), 0);
      check("midreset.valid", 32'(valid), 0);
      check("midreset.dx", 32'(dx), 0);
      check("midreset.dy", 32'(dy), 0);
      check("midreset.present", 32'(mouse_present), 0);
      check("midreset.busy", 32'(busy), 0);
      repeat (2) @(negedge clk_sys);
      reset_n     = 1'b1;
      ref_miss    = 0;
      ref_present = 1'b0;

      // Abort after the second toggle, then a clean frame after re-enable.
      load_device(16'h5678, 2'b00, 1'b0);
      cyc = 0; edges = 0; prev = str_out;
      while (edges < 2 && cyc < FRAME_BOUND) begin
         @(negedge clk_sys);
         cyc++;
         if (str_out !== prev) begin
            prev = str_out;
            edges++;
         end
      end
      check("abort.two_edges", 32'(edges), 2);
      repeat (3) @(negedge clk_sys);
      enable = 1'b0;
      @(negedge clk_sys);
      check("abort.busy", 32'(busy), 0);
      str_hold = str_out;
      vcount = 0; scount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         if (valid) vcount++;
         if (str_out !== str_hold) scount++;
      end
      check("abort.no_valid", 32'(vcount), 0);
      check("abort.str_held", 32'(scount), 0);
      load_device(16'h1234, 2'b00, 1'b0);
      predict(16'h1234, 2'b00, 1'b0, pdx, pdxn, pdy, pbtn, ppres);
      enable = 1'b1;
      run_frame("resync", 8'h12, 8'hEE, 8'h34, 2'b00, 1'b1);

      for (int i = 0; i < 10; i++) begin
         logic [15:0] w;
         logic [1:0]  b;
         bit          f;
         w = 16'($urandom);
         b = 2'($urandom);
         f = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) w = 16'hFFFF;
         load_device(w, b, f);
         predict(w, b, f, pdx, pdxn, pdy, pbtn, ppres);
         run_frame($sformatf("rand%0d", i), pdx, pdxn, pdy, pbtn, ppres);
      end

      // Long disable: nothing may move.
      enable   = 1'b0;
      @(negedge clk_sys);
      str_hold = str_out;
      vcount = 0; scount = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk_sys);
         if (valid || busy) vcount++;
         if (str_out !== str_hold) scount++;
      end
      check("disabled.no_activity", 32'(vcount), 0);
      check("disabled.str_const", 32'(scount), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
